// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename tags. Resolves issuing
// operands to a value or a pending ROB tag and registers the result for RS/LSB.
module reg_status_file #(
  parameter int unsigned REG_N   = 32,
  parameter int unsigned REG_BIT = 5,
  parameter int unsigned ROB_BIT = 5,
  parameter int unsigned DAT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               br_flag_i,
  input  logic               is_en_i,
  input  logic [REG_BIT-1:0] is_rs1_i,
  input  logic [REG_BIT-1:0] is_rs2_i,
  input  logic [REG_BIT-1:0] is_rd_i,
  input  logic               is_wr_i,
  input  logic [ROB_BIT-1:0] is_qd_i,
  input  logic               cmt_en_i,
  input  logic [REG_BIT-1:0] cmt_rd_i,
  input  logic [ROB_BIT-1:0] cmt_q_i,
  input  logic [DAT_W-1:0]   cmt_v_i,
  input  logic               cdb_en_i,
  input  logic [ROB_BIT-1:0] cdb_q_i,
  input  logic [DAT_W-1:0]   cdb_v_i,
  output logic [ROB_BIT-1:0] rob_reqqj_o,
  output logic [ROB_BIT-1:0] rob_reqqk_o,
  input  logic               rob_rdyj_i,
  input  logic               rob_rdyk_i,
  input  logic [DAT_W-1:0]   rob_vj_i,
  input  logic [DAT_W-1:0]   rob_vk_i,
  output logic               out_en_o,
  output logic [ROB_BIT-1:0] out_qj_o,
  output logic [ROB_BIT-1:0] out_qk_o,
  output logic [DAT_W-1:0]   out_vj_o,
  output logic [DAT_W-1:0]   out_vk_o,
  output logic [ROB_BIT-1:0] out_qd_o
);

  typedef struct packed {
    logic [ROB_BIT-1:0] q;
    logic [DAT_W-1:0]   v;
  } opnd_t;

  logic [DAT_W-1:0]   r_val [REG_N];
  logic [ROB_BIT-1:0] r_tag [REG_N];

  logic [ROB_BIT-1:0] w_tagj;
  logic [ROB_BIT-1:0] w_tagk;
  logic               w_ren;
  opnd_t              w_opj;
  opnd_t              w_opk;

  function automatic opnd_t resolve(
    input logic [REG_BIT-1:0] rs,
    input logic [ROB_BIT-1:0] tag,
    input logic [DAT_W-1:0]   val,
    input logic               rdy,
    input logic [DAT_W-1:0]   rob_v
  );
    opnd_t o;
    o = '0;
    if (rs == '0) begin
      o = '0;
    end else if (tag == '0) begin
      o.v = val;
    end else if (cmt_en_i && cmt_q_i == tag) begin
      o.v = cmt_v_i;
    end else if (cdb_en_i && cdb_q_i == tag) begin
      o.v = cdb_v_i;
    end else if (rdy) begin
      o.v = rob_v;
    end else begin
      o.q = tag;
    end
    return o;
  endfunction

  always_comb begin
    w_tagj = r_tag[is_rs1_i];
    w_tagk = r_tag[is_rs2_i];
    w_ren  = is_en_i && is_wr_i && !br_flag_i;
    w_opj  = resolve(is_rs1_i, w_tagj, r_val[is_rs1_i], rob_rdyj_i, rob_vj_i);
    w_opk  = resolve(is_rs2_i, w_tagk, r_val[is_rs2_i], rob_rdyk_i, rob_vk_i);
  end

  assign rob_reqqj_o = w_tagj;
  assign rob_reqqk_o = w_tagk;

  // Entry 0 is only ever reset, which keeps x0 hardwired to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < REG_N; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
    end else if (en) begin
      for (int unsigned i = 1; i < REG_N; i++) begin
        if (cmt_en_i && cmt_rd_i == REG_BIT'(i))
          r_val[i] <= cmt_v_i;
        // Rename wins over a same-cycle commit clear; flush wins over both.
        if (br_flag_i)
          r_tag[i] <= '0;
        else if (w_ren && is_rd_i == REG_BIT'(i))
          r_tag[i] <= is_qd_i;
        else if (cmt_en_i && cmt_rd_i == REG_BIT'(i) && r_tag[i] == cmt_q_i)
          r_tag[i] <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_en_o <= 1'b0;
      out_qj_o <= '0;
      out_qk_o <= '0;
      out_vj_o <= '0;
      out_vk_o <= '0;
      out_qd_o <= '0;
    end else if (en) begin
      out_en_o <= is_en_i && !br_flag_i;
      out_qj_o <= w_opj.q;
      out_qk_o <= w_opk.q;
      out_vj_o <= w_opj.v;
      out_vk_o <= w_opk.v;
      out_qd_o <= is_qd_i;
    end else begin
      out_en_o <= 1'b0;
    end
  end

endmodule
